// File: rtl/analog_stick.sv
// analog_stick: four 8-bit stick positions (two players, X/Y each) driven either
// by digital direction inputs that ramp the position on a prescaled tick, or by
// strobed signed analog samples converted to offset binary and clamped.
module analog_stick #(
  parameter logic [15:0] TICK_DIV = 16'd6000,
  parameter logic [7:0]  STEP     = 8'd4,
  parameter logic [7:0]  CENTER   = 8'h80,
  parameter logic [7:0]  PMIN     = 8'h10,
  parameter logic [7:0]  PMAX     = 8'hF0
) (
  input  logic       cl,
  input  logic       reset,
  input  logic [3:0] JOY0,
  input  logic [3:0] JOY1,
  input  logic [1:0] ANA_EN,
  input  logic       ANA_STB,
  input  logic [7:0] ANA_X0,
  input  logic [7:0] ANA_Y0,
  input  logic [7:0] ANA_X1,
  input  logic [7:0] ANA_Y1,
  input  logic       HOLD,
  output logic [7:0] AX0,
  output logic [7:0] AY0,
  output logic [7:0] AX1,
  output logic [7:0] AY1
);

  // axis index: 0 = AX0, 1 = AY0, 2 = AX1, 3 = AY1
  logic [15:0] div_cnt;
  logic        tick;
  logic [7:0]  pos_q [4];
  logic [7:0]  pos_d [4];

  assign tick = (div_cnt == TICK_DIV - 16'd1);

  // One digital ramp step; 9-bit sums catch overflow/underflow before saturation.
  function automatic logic [7:0] ramp(input logic [7:0] pos, input logic inc, input logic dec);
    logic [8:0] up9;
    logic [8:0] dn9;
    logic [7:0] res;
    up9 = {1'b0, pos} + {1'b0, STEP};
    dn9 = {1'b0, pos} - {1'b0, STEP};
    res = pos;
    if (inc && !dec)
      res = (up9 > {1'b0, PMAX}) ? PMAX : up9[7:0];
    else if (dec && !inc)
      res = (dn9[8] || (dn9[7:0] < PMIN)) ? PMIN : dn9[7:0];
    else if (pos > CENTER)
      res = (dn9[8] || (dn9[7:0] < CENTER)) ? CENTER : dn9[7:0];
    else if (pos < CENTER)
      res = (up9 > {1'b0, CENTER}) ? CENTER : up9[7:0];
    return res;
  endfunction

  // Signed sample to offset binary (flip the sign bit), then limit to the legal window.
  function automatic logic [7:0] clamp(input logic [7:0] sample);
    logic [7:0] v;
    v = sample ^ 8'h80;
    if (v < PMIN)
      v = PMIN;
    else if (v > PMAX)
      v = PMAX;
    return v;
  endfunction

  // Prescaler: free-running 0..TICK_DIV-1, unaffected by HOLD.
  always_ff @(posedge cl) begin
    if (reset)
      div_cnt <= '0;
    else if (tick)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 16'd1;
  end

  // Next position per axis: each player follows its own mode; HOLD freezes everything.
  always_comb begin
    for (int a = 0; a < 4; a++)
      pos_d[a] = pos_q[a];
    if (!HOLD) begin
      if (ANA_EN[0]) begin
        if (ANA_STB) begin
          pos_d[0] = clamp(ANA_X0);
          pos_d[1] = clamp(ANA_Y0);
        end
      end else if (tick) begin
        pos_d[0] = ramp(pos_q[0], JOY0[0], JOY0[1]);
        pos_d[1] = ramp(pos_q[1], JOY0[2], JOY0[3]);
      end
      if (ANA_EN[1]) begin
        if (ANA_STB) begin
          pos_d[2] = clamp(ANA_X1);
          pos_d[3] = clamp(ANA_Y1);
        end
      end else if (tick) begin
        pos_d[2] = ramp(pos_q[2], JOY1[0], JOY1[1]);
        pos_d[3] = ramp(pos_q[3], JOY1[2], JOY1[3]);
      end
    end
  end

  // Position registers; reset returns all sticks to rest.
  always_ff @(posedge cl) begin
    for (int a = 0; a < 4; a++) begin
      if (reset)
        pos_q[a] <= CENTER;
      else
        pos_q[a] <= pos_d[a];
    end
  end

  assign AX0 = pos_q[0];
  assign AY0 = pos_q[1];
  assign AX1 = pos_q[2];
  assign AY1 = pos_q[3];

endmodule

// File: tb/tb_analog_stick.sv
// Bench for analog_stick: directed vector table, reset corner sequence, and
// randomized run against a behavioural model.
module tb_analog_stick;

  localparam int TD = 4;
  localparam int ST = 8;
  localparam int CT = 'h80;
  localparam int MN = 'h10;
  localparam int MX = 'hF0;

  logic       cl = 1'b0;
  logic       reset;
  logic [3:0] JOY0, JOY1;
  logic [1:0] ANA_EN;
  logic       ANA_STB;
  logic [7:0] ANA_X0, ANA_Y0, ANA_X1, ANA_Y1;
  logic       HOLD;
  logic [7:0] AX0, AY0, AX1, AY1;

  int checks = 0;
  int failures = 0;

  int m_pos [4];
  int m_cyc;

  analog_stick #(
    .TICK_DIV(16'd4), .STEP(8'd8), .CENTER(8'h80), .PMIN(8'h10), .PMAX(8'hF0)
  ) dut (
    .cl(cl), .reset(reset), .JOY0(JOY0), .JOY1(JOY1), .ANA_EN(ANA_EN),
    .ANA_STB(ANA_STB), .ANA_X0(ANA_X0), .ANA_Y0(ANA_Y0), .ANA_X1(ANA_X1),
    .ANA_Y1(ANA_Y1), .HOLD(HOLD), .AX0(AX0), .AY0(AY0), .AX1(AX1), .AY1(AY1)
  );

  always #5 cl = ~cl;

  typedef struct {
    logic [3:0] j0;
    logic [3:0] j1;
    logic [1:0] en;
    logic       stb;
    logic [7:0] x0;
    logic [7:0] y0;
    logic       hold;
    int         ncyc;
    int         e_ax0;
    int         e_ay0;
    int         e_ax1;
    int         e_ay1;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int dig(input int pos, input bit inc, input bit dec);
    if (inc && !dec) return (pos + ST > MX) ? MX : pos + ST;
    if (dec && !inc) return (pos - ST < MN) ? MN : pos - ST;
    if (pos > CT) return (pos - ST < CT) ? CT : pos - ST;
    if (pos < CT) return (pos + ST > CT) ? CT : pos + ST;
    return pos;
  endfunction

  function automatic int ana(input logic [7:0] s);
    int v;
    v = $signed(s);
    v = v + 128;
    if (v < MN) v = MN;
    if (v > MX) v = MX;
    return v;
  endfunction

  // Reference model: tick every TD cycles counted from the last reset edge.
  task automatic model_step();
    bit tk;
    if (reset) begin
      for (int a = 0; a < 4; a++) m_pos[a] = CT;
      m_cyc = 0;
      return;
    end
    m_cyc++;
    tk = (m_cyc % TD) == 0;
    if (HOLD) return;
    if (ANA_EN[0]) begin
      if (ANA_STB) begin m_pos[0] = ana(ANA_X0); m_pos[1] = ana(ANA_Y0); end
    end else if (tk) begin
      m_pos[0] = dig(m_pos[0], JOY0[0], JOY0[1]);
      m_pos[1] = dig(m_pos[1], JOY0[2], JOY0[3]);
    end
    if (ANA_EN[1]) begin
      if (ANA_STB) begin m_pos[2] = ana(ANA_X1); m_pos[3] = ana(ANA_Y1); end
    end else if (tk) begin
      m_pos[2] = dig(m_pos[2], JOY1[0], JOY1[1]);
      m_pos[3] = dig(m_pos[3], JOY1[2], JOY1[3]);
    end
  endtask

  task automatic cycle();
    @(posedge cl);
    model_step();
    #1;
  endtask

  task automatic check_all(input string tag, input int e0, input int e1, input int e2, input int e3);
    check({tag, ".AX0"}, int'(AX0), e0);
    check({tag, ".AY0"}, int'(AY0), e1);
    check({tag, ".AX1"}, int'(AX1), e2);
    check({tag, ".AY1"}, int'(AY1), e3);
  endtask

  initial begin
    reset = 1'b1; JOY0 = '0; JOY1 = '0; ANA_EN = '0; ANA_STB = 1'b0;
    ANA_X0 = '0; ANA_Y0 = '0; ANA_X1 = '0; ANA_Y1 = '0; HOLD = 1'b0;
    for (int a = 0; a < 4; a++) m_pos[a] = CT;
    m_cyc = 0;

    //            j0     j1     en     stb   x0     y0     hold ncyc ax0   ay0   ax1   ay1
    vecs[0]  = '{4'h1, 4'h0, 2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 4,  'h88, 'h80, 'h80, 'h80};
    vecs[1]  = '{4'h1, 4'h0, 2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 4,  'h90, 'h80, 'h80, 'h80};
    vecs[2]  = '{4'h1, 4'h0, 2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 48, 'hF0, 'h80, 'h80, 'h80};
    vecs[3]  = '{4'h1, 4'h0, 2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 8,  'hF0, 'h80, 'h80, 'h80};
    vecs[4]  = '{4'h0, 4'h0, 2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 4,  'hE8, 'h80, 'h80, 'h80};
    vecs[5]  = '{4'h0, 4'h0, 2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 52, 'h80, 'h80, 'h80, 'h80};
    vecs[6]  = '{4'h0, 4'h0, 2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 8,  'h80, 'h80, 'h80, 'h80};
    vecs[7]  = '{4'h0, 4'h0, 2'b01, 1'b1, 8'h04, 8'h00, 1'b0, 1,  'h84, 'h80, 'h80, 'h80};
    vecs[8]  = '{4'h0, 4'h0, 2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 3,  'h80, 'h80, 'h80, 'h80};
    vecs[9]  = '{4'h0, 4'h3, 2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 8,  'h80, 'h80, 'h80, 'h80};
    vecs[10] = '{4'h0, 4'h4, 2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 8,  'h80, 'h80, 'h80, 'h90};
    vecs[11] = '{4'h0, 4'hC, 2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 4,  'h80, 'h80, 'h80, 'h88};
    vecs[12] = '{4'h0, 4'h1, 2'b01, 1'b1, 8'h7F, 8'h80, 1'b0, 1,  'hF0, 'h10, 'h80, 'h88};
    vecs[13] = '{4'h0, 4'h1, 2'b01, 1'b0, 8'h7F, 8'h80, 1'b0, 3,  'hF0, 'h10, 'h88, 'h80};
    vecs[14] = '{4'h0, 4'h1, 2'b01, 1'b1, 8'h00, 8'h00, 1'b0, 1,  'h80, 'h80, 'h88, 'h80};
    vecs[15] = '{4'h1, 4'h1, 2'b00, 1'b1, 8'h7F, 8'h7F, 1'b1, 20, 'h80, 'h80, 'h88, 'h80};
    vecs[16] = '{4'h1, 4'h1, 2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 3,  'h88, 'h80, 'h90, 'h80};

    repeat (2) cycle();
    check_all("reset", CT, CT, CT, CT);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      JOY0 = vecs[i].j0; JOY1 = vecs[i].j1; ANA_EN = vecs[i].en;
      ANA_STB = vecs[i].stb; ANA_X0 = vecs[i].x0; ANA_Y0 = vecs[i].y0;
      ANA_X1 = vecs[i].x0; ANA_Y1 = vecs[i].y0; HOLD = vecs[i].hold;
      cycle();
      ANA_STB = 1'b0;
      for (int c = 1; c < vecs[i].ncyc; c++) cycle();
      check_all($sformatf("vec%0d", i), vecs[i].e_ax0, vecs[i].e_ay0, vecs[i].e_ax1, vecs[i].e_ay1);
    end

    // Reset landing on a due tick, then first tick TD cycles after release.
    JOY0 = 4'h8; JOY1 = 4'h0; ANA_EN = 2'b00; HOLD = 1'b0;
    reset = 1'b1; cycle(); reset = 1'b0;
    repeat (40) cycle();
    check("rst_seq.AY0_ramped", int'(AY0), 'h30);
    repeat (3) cycle();
    check("rst_seq.AY0_pre", int'(AY0), 'h30);
    reset = 1'b1; cycle(); reset = 1'b0;
    check_all("rst_seq.reset", CT, CT, CT, CT);
    for (int c = 1; c <= 3; c++) begin
      cycle();
      check($sformatf("rst_seq.no_tick%0d", c), int'(AY0), 'h80);
    end
    cycle();
    check("rst_seq.first_tick", int'(AY0), 'h78);

    // Randomized run against the model.
    reset = 1'b1; cycle(); reset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      HOLD = ($urandom_range(0, 9) == 0);
      ANA_STB = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) ANA_EN = 2'($urandom);
      if ($urandom_range(0, 5) == 0) begin JOY0 = 4'($urandom); JOY1 = 4'($urandom); end
      ANA_X0 = 8'($urandom); ANA_Y0 = 8'($urandom);
      ANA_X1 = 8'($urandom); ANA_Y1 = 8'($urandom);
      cycle();
      check_all($sformatf("rand%0d", n), m_pos[0], m_pos[1], m_pos[2], m_pos[3]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
